// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared state type and sizing helpers for the scan chain loader
// Contents: scan_state_e (loader FSM states), ceil_div, clog2.
package scan_pkg;

  typedef enum logic [1:0] {
    SCAN_IDLE  = 2'd0,
    SCAN_SHIFT = 2'd1,
    SCAN_DONE  = 2'd2
  } scan_state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // ceil(log2(v)), never below 1 so the result can size a vector directly
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/scan_readback_packer.sv
// rtl/scan_readback_packer.sv - serial-to-word packer for chain readback
// Ports:
//   clk_i, rst_ni           clock, synchronous active-low reset
//   sample_en_i             capture sample_bit_i this cycle
//   sample_bit_i            serial bit, first bit lands in the word MSB
//   flush_i                 this sample is the last of the load; emit a partial word
//   rd_data_o, rd_valid_o   packed word and its one-cycle valid pulse
module scan_readback_packer
  import scan_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sample_en_i,
  input  logic              sample_bit_i,
  input  logic              flush_i,
  output logic [WORD_W-1:0] rd_data_o,
  output logic              rd_valid_o
);

  localparam int CW = clog2(WORD_W);

  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic [WORD_W-1:0] acc_nxt;
  logic              word_full;

  always_comb begin
    acc_nxt    = {acc_q[WORD_W-2:0], sample_bit_i};
    word_full  = (cnt_q == CW'(WORD_W - 1));
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (sample_en_i) begin
      if (word_full || flush_i) begin
        // A short final word is left-aligned: shift out the unused low bits.
        rd_data_d  = acc_nxt << (CW'(WORD_W - 1) - cnt_q);
        rd_valid_d = 1'b1;
        acc_d      = '0;
        cnt_d      = '0;
      end else begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/scan_chain_loader.sv
// rtl/scan_chain_loader.sv - parallel-to-serial loader for the configuration scan chain
// Ports:
//   scan_clk, scan_rst_n          clock (shared with the chain), synchronous active-low reset
//   start                         begin one full-chain load (ignored while busy)
//   wr_data, wr_valid, wr_ready   configuration word stream, MSB shifted first
//   chain_in, chain_en            scan_in of stage 0, scan_en of all stages
//   chain_out                     scan_out of the last stage
//   rd_data, rd_valid             readback words of the previous chain contents
//   busy, done                    load in progress, one-cycle completion pulse
module scan_chain_loader
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              scan_clk,
  input  logic              scan_rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              chain_in,
  output logic              chain_en,
  input  logic              chain_out,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done
);

  localparam int NWORDS = ceil_div(CHAIN_LEN, WORD_W);
  localparam int BL_W   = clog2(CHAIN_LEN + 1);
  localparam int BI_W   = clog2(WORD_W + 1);
  localparam int WL_W   = clog2(NWORDS + 1);

  scan_state_e       state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic              have_word_q, have_word_d;
  logic [BI_W-1:0]   bit_idx_q, bit_idx_d;
  logic [BL_W-1:0]   bits_left_q, bits_left_d;
  logic [WL_W-1:0]   words_left_q, words_left_d;

  logic              in_shift, shift_now, word_last_bit, chain_last_bit, take_word;
  logic [BL_W-1:0]   bits_after;

  assign in_shift       = (state_q == SCAN_SHIFT);
  assign shift_now      = in_shift && have_word_q;
  assign word_last_bit  = shift_now && (bit_idx_q == BI_W'(1));
  assign chain_last_bit = shift_now && (bits_left_q == BL_W'(1));
  assign take_word      = wr_ready && wr_valid;

  always_ff @(posedge scan_clk) begin
    if (!scan_rst_n) state_q <= SCAN_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN_IDLE:  if (start) state_d = SCAN_SHIFT;
      SCAN_SHIFT: if (chain_last_bit) state_d = SCAN_DONE;
      SCAN_DONE:  state_d = SCAN_IDLE;
      default:    state_d = SCAN_IDLE;
    endcase
  end

  always_comb begin
    // A word may be taken while the previous word's last bit shifts, so
    // back-to-back words run without a bubble on chain_en.
    wr_ready = in_shift && (words_left_q != '0) && (!have_word_q || word_last_bit);
    chain_en = shift_now;
    chain_in = sreg_q[WORD_W-1];
    busy     = (state_q != SCAN_IDLE);
    done     = (state_q == SCAN_DONE);
  end

  always_comb begin
    sreg_d       = sreg_q;
    have_word_d  = have_word_q;
    bit_idx_d    = bit_idx_q;
    bits_left_d  = bits_left_q;
    words_left_d = words_left_q;
    bits_after   = bits_left_q - BL_W'(shift_now);
    if (state_q == SCAN_IDLE) begin
      if (start) begin
        bits_left_d  = BL_W'(CHAIN_LEN);
        words_left_d = WL_W'(NWORDS);
        have_word_d  = 1'b0;
        bit_idx_d    = '0;
        sreg_d       = '0;
      end
    end else if (in_shift) begin
      if (shift_now) begin
        sreg_d      = sreg_q << 1;
        bit_idx_d   = bit_idx_q - BI_W'(1);
        bits_left_d = bits_after;
        if (word_last_bit) have_word_d = 1'b0;
      end
      if (take_word) begin
        sreg_d       = wr_data;
        have_word_d  = 1'b1;
        words_left_d = words_left_q - WL_W'(1);
        // The final word may cover fewer chain bits than WORD_W; its low bits are dropped.
        bit_idx_d    = (int'(bits_after) < WORD_W) ? BI_W'(bits_after) : BI_W'(WORD_W);
      end
    end else begin
      sreg_d = '0;
    end
  end

  always_ff @(posedge scan_clk) begin
    if (!scan_rst_n) begin
      sreg_q       <= '0;
      have_word_q  <= 1'b0;
      bit_idx_q    <= '0;
      bits_left_q  <= '0;
      words_left_q <= '0;
    end else begin
      sreg_q       <= sreg_d;
      have_word_q  <= have_word_d;
      bit_idx_q    <= bit_idx_d;
      bits_left_q  <= bits_left_d;
      words_left_q <= words_left_d;
    end
  end

  scan_readback_packer #(
    .WORD_W(WORD_W)
  ) u_packer (
    .clk_i        (scan_clk),
    .rst_ni       (scan_rst_n),
    .sample_en_i  (chain_en),
    .sample_bit_i (chain_out),
    .flush_i      (chain_last_bit),
    .rd_data_o    (rd_data),
    .rd_valid_o   (rd_valid)
  );

endmodule

// File: tb/tb_scan_chain_loader.sv
// tb/tb_scan_chain_loader.sv - self-checking bench for scan_chain_loader (12-bit and 16-bit chains)
module tb_scan_chain_loader;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start[2], wr_valid[2], wr_ready[2], chain_in[2], chain_en[2];
  logic         chain_out[2], rd_valid[2], busy[2], done[2];
  logic [W-1:0] wr_data[2], rd_data[2];
  logic [15:0]  chain[2] = '{16'h0, 16'h0};

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  scan_chain_loader #(.CHAIN_LEN(12), .WORD_W(W)) dut0 (
    .scan_clk(clk), .scan_rst_n(rst_n), .start(start[0]), .wr_data(wr_data[0]),
    .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]), .chain_in(chain_in[0]),
    .chain_en(chain_en[0]), .chain_out(chain_out[0]), .rd_data(rd_data[0]),
    .rd_valid(rd_valid[0]), .busy(busy[0]), .done(done[0])
  );

  scan_chain_loader #(.CHAIN_LEN(16), .WORD_W(W)) dut1 (
    .scan_clk(clk), .scan_rst_n(rst_n), .start(start[1]), .wr_data(wr_data[1]),
    .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]), .chain_in(chain_in[1]),
    .chain_en(chain_en[1]), .chain_out(chain_out[1]), .rd_data(rd_data[1]),
    .rd_valid(rd_valid[1]), .busy(busy[1]), .done(done[1])
  );

  // Attached chains: stage 0 is bit 0, the tail is bit LEN-1.
  assign chain_out[0] = chain[0][11];
  assign chain_out[1] = chain[1][15];

  always @(posedge clk) begin
    if (chain_en[0]) chain[0] <= {4'h0, chain[0][10:0], chain_in[0]};
    if (chain_en[1]) chain[1] <= {chain[1][14:0], chain_in[1]};
  end

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d: got %h want %h", nm, g, act, exp);
    end
  endtask

  function automatic int len_of(input int g);
    return (g == 0) ? 12 : 16;
  endfunction

  // Reference model: the load is a stream of bits cut from accepted words;
  // one bit leaves per enabled cycle, and tail samples are grouped into words.
  int         ph[2];
  int         acc_bits[2], shifted[2], words_acc[2], rb_n[2];
  logic       strm[2][16];
  logic [7:0] rb[2], e_rdd[2];
  logic       e_rdv[2], post_rst[2];
  logic       armed = 1'b0;

  always @(negedge clk) begin
    int   L, nph;
    logic e_en, e_rdy;
    if (!rst_n) begin
      armed = 1'b1;
      for (int g = 0; g < 2; g++) begin
        ph[g] = 0; acc_bits[g] = 0; shifted[g] = 0; words_acc[g] = 0;
        rb[g] = 8'h0; rb_n[g] = 0; e_rdv[g] = 1'b0; post_rst[g] = 1'b1;
      end
    end else if (armed) begin
      for (int g = 0; g < 2; g++) begin
        L     = len_of(g);
        e_en  = (ph[g] == 1) && (shifted[g] < acc_bits[g]);
        e_rdy = (ph[g] == 1) && (words_acc[g] < (L + W - 1) / W) &&
                ((shifted[g] == acc_bits[g]) || (e_en && (shifted[g] + 1 == acc_bits[g])));
        chk("chain_en", g, 32'(chain_en[g]), 32'(e_en));
        chk("wr_ready", g, 32'(wr_ready[g]), 32'(e_rdy));
        chk("busy", g, 32'(busy[g]), 32'(ph[g] != 0));
        chk("done", g, 32'(done[g]), 32'(ph[g] == 2));
        chk("rd_valid", g, 32'(rd_valid[g]), 32'(e_rdv[g]));
        if (e_rdv[g]) chk("rd_data", g, 32'(rd_data[g]), 32'(e_rdd[g]));
        if (e_en) chk("chain_in", g, 32'(chain_in[g]), 32'(strm[g][shifted[g]]));
        if (post_rst[g]) begin
          chk("rst_chain_in", g, 32'(chain_in[g]), 32'h0);
          chk("rst_rd_data", g, 32'(rd_data[g]), 32'h0);
        end
        e_rdv[g] = 1'b0;
        post_rst[g] = 1'b0;
        nph = ph[g];
        if (ph[g] == 0 && start[g]) begin
          nph = 1; acc_bits[g] = 0; shifted[g] = 0; words_acc[g] = 0;
        end
        if (ph[g] == 2) nph = 0;
        if (e_en) begin
          rb[g] = {rb[g][6:0], chain_out[g]};
          rb_n[g]++;
          shifted[g]++;
          if (rb_n[g] == W || shifted[g] == L) begin
            e_rdd[g] = rb[g] << (W - rb_n[g]);
            e_rdv[g] = 1'b1;
            rb[g] = 8'h0;
            rb_n[g] = 0;
          end
          if (shifted[g] == L) nph = 2;
        end
        if (e_rdy && wr_valid[g]) begin
          words_acc[g]++;
          for (int j = W - 1; j >= 0; j--) begin
            if (acc_bits[g] < L) begin
              strm[g][acc_bits[g]] = wr_data[g][j];
              acc_bits[g]++;
            end
          end
        end
        ph[g] = nph;
      end
    end
  end

  task automatic load(input int g, input logic [7:0] w0, input logic [7:0] w1,
                      input int stall, input int restart_at,
                      output int dur, output int en_cnt, output int en_run, output int ndone,
                      output logic [7:0] rd0, output logic [7:0] rd1, output logic overlap);
    int idx, stall_left, t0, run, nrd, after;
    logic [7:0] wds[2];
    wds[0] = w0; wds[1] = w1;
    idx = 0; stall_left = stall; en_cnt = 0; en_run = 0; run = 0; ndone = 0;
    nrd = 0; rd0 = 8'h0; rd1 = 8'h0; overlap = 1'b0; dur = -1; after = -1;
    start[g] = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start[g] = 1'b0;
    for (int k = 1; k < 200 && after != 0; k++) begin
      start[g]    = (k == restart_at);
      wr_data[g]  = wds[(idx < 2) ? idx : 1];
      wr_valid[g] = (idx < 2) && !(idx == 1 && stall_left > 0);
      @(negedge clk);
      if (chain_en[g]) begin
        en_cnt++; run++;
        if (run > en_run) en_run = run;
      end else run = 0;
      if (idx == 1 && wr_ready[g] && chain_en[g]) overlap = 1'b1;
      if (rd_valid[g]) begin
        if (nrd == 0) rd0 = rd_data[g]; else rd1 = rd_data[g];
        nrd++;
      end
      if (done[g]) begin
        ndone++;
        if (dur < 0) begin dur = cyc - t0; after = 4; end
      end
      if (wr_valid[g] && wr_ready[g]) idx++;
      else if (idx == 1 && wr_ready[g] && stall_left > 0) stall_left--;
      if (after > 0) after--;
      @(posedge clk); #1;
    end
    start[g] = 1'b0;
    wr_valid[g] = 1'b0;
    if (dur < 0) chk("load_timeout", g, 32'h1, 32'h0);
  endtask

  initial begin
    int dur, en_cnt, en_run, ndone, base16, guard, n;
    logic [7:0] rd0, rd1;
    logic ovl;
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0; wr_valid[g] = 1'b0; wr_data[g] = 8'h0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", 0, 32'(busy[0]), 32'h0);
    chk("reset_rd_data", 1, 32'(rd_data[1]), 32'h0);
    @(posedge clk); #1;

    // Load 0xA5, 0x3F into the 12-bit chain, wr_valid held high.
    load(0, 8'hA5, 8'h3F, 0, 0, dur, en_cnt, en_run, ndone, rd0, rd1, ovl);
    chk("t1_chain", 0, 32'(chain[0]), 32'h0A53);
    chk("t1_en_cycles", 0, en_cnt, 12);
    chk("t1_en_run", 0, en_run, 12);
    chk("t1_done_lat", 0, dur, 14);
    chk("t1_ndone", 0, ndone, 1);

    // Reload with zeros: the previous contents come back as 0xA5, 0x30.
    load(0, 8'h00, 8'h00, 0, 0, dur, en_cnt, en_run, ndone, rd0, rd1, ovl);
    chk("t2_rd0", 0, 32'(rd0), 32'hA5);
    chk("t2_rd1", 0, 32'(rd1), 32'h30);
    chk("t2_chain", 0, 32'(chain[0]), 32'h0000);

    // Back-to-back 0xFF, 0x01 on the 16-bit chain.
    load(1, 8'hFF, 8'h01, 0, 0, dur, en_cnt, en_run, ndone, rd0, rd1, ovl);
    base16 = dur;
    chk("t6_overlap_ready", 1, 32'(ovl), 32'h1);
    chk("t6_en_run", 1, en_run, 16);
    chk("t6_chain", 1, 32'(chain[1]), 32'hFF01);
    chk("t6_done_lat", 1, dur, 18);

    // Three stall cycles between words on the 16-bit chain.
    load(1, 8'hC3, 8'h5A, 3, 0, dur, en_cnt, en_run, ndone, rd0, rd1, ovl);
    chk("t3_chain", 1, 32'(chain[1]), 32'hC35A);
    chk("t3_en_cycles", 1, en_cnt, 16);
    chk("t3_en_run", 1, en_run, 8);
    chk("t3_done_lat", 1, dur, 21);
    chk("t3_stall_delta", 1, dur - base16, 3);
    chk("t3_rd0", 1, 32'(rd0), 32'hFF);
    chk("t3_rd1", 1, 32'(rd1), 32'h01);

    // wr_valid while idle, then a repeated start mid-load.
    wr_valid[0] = 1'b1; wr_data[0] = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_idle_ready", 0, 32'(wr_ready[0]), 32'h0);
      @(posedge clk); #1;
    end
    load(0, 8'h5C, 8'h9E, 0, 5, dur, en_cnt, en_run, ndone, rd0, rd1, ovl);
    chk("t4_ndone", 0, ndone, 1);
    chk("t4_chain", 0, 32'(chain[0]), 32'h05C9);
    chk("t4_done_lat", 0, dur, 14);

    // Reset after five shifts, then a clean full load.
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0; wr_data[0] = 8'hFF; wr_valid[0] = 1'b1;
    n = 0; guard = 0;
    while (n < 5 && guard < 50) begin
      @(negedge clk);
      if (chain_en[0]) n++;
      guard++;
      @(posedge clk); #1;
    end
    chk("t5_shifts_seen", 0, n, 5);
    rst_n = 1'b0; wr_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_busy", 0, 32'(busy[0]), 32'h0);
    chk("t5_chain_en", 0, 32'(chain_en[0]), 32'h0);
    chk("t5_chain_in", 0, 32'(chain_in[0]), 32'h0);
    chk("t5_rd_data", 0, 32'(rd_data[0]), 32'h0);
    @(posedge clk); #1;
    load(0, 8'h12, 8'h34, 0, 0, dur, en_cnt, en_run, ndone, rd0, rd1, ovl);
    chk("t5_chain", 0, 32'(chain[0]), 32'h0123);
    chk("t5_done_lat", 0, dur, 14);
    chk("t5_en_cycles", 0, en_cnt, 12);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
